// File: rtl/error_lock_monitor_if.sv
// Sample/result bundle between the ADPLL phase-error source and the lock monitor.
interface error_lock_monitor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sample_i;
    logic [WIDTH-1:0] error_i;
    logic [WIDTH-1:0] avg_o;
    logic             avg_valid_o;
    logic [WIDTH-1:0] peak_o;
    logic             locked_o;
    logic             lock_lost_o;

    // Error producer side (ADPLL / testbench)
    modport master (
        output sample_i,
        output error_i,
        input  avg_o,
        input  avg_valid_o,
        input  peak_o,
        input  locked_o,
        input  lock_lost_o
    );

    // Monitor side
    modport slave (
        input  sample_i,
        input  error_i,
        output avg_o,
        output avg_valid_o,
        output peak_o,
        output locked_o,
        output lock_lost_o
    );
endinterface

// File: rtl/error_lock_monitor.sv
// Windowed average / peak of the ADPLL phase error with hysteretic lock detect.
module error_lock_monitor #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned LOG2_SAMPLES = 4,
    parameter int unsigned LOCK_THRESH  = 2,
    parameter int unsigned LOCK_COUNT   = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    error_lock_monitor_if.slave bus
);

    localparam int unsigned ACC_W  = WIDTH + LOG2_SAMPLES;
    localparam int unsigned CNT_W  = LOG2_SAMPLES;
    localparam int unsigned LCNT_W = 8;

    localparam logic [WIDTH:0]       THRESH_GOOD = (WIDTH+1)'(LOCK_THRESH);
    localparam logic [WIDTH:0]       THRESH_BAD  = (WIDTH+1)'(2 * LOCK_THRESH);
    localparam logic [LCNT_W-1:0]    LCNT_TARGET = LCNT_W'(LOCK_COUNT);
    localparam logic [WIDTH-1:0]     ERR_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]     ERR_MAX_MAG = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        ACQUIRING = 2'd1,
        LOCKED    = 2'd2
    } state_t;

    // Window accumulation state
    logic signed [ACC_W-1:0] acc_q;
    logic [WIDTH-1:0]        run_peak_q;
    logic [CNT_W-1:0]        count_q;

    // Registered outputs
    logic signed [WIDTH-1:0] avg_q;
    logic [WIDTH-1:0]        peak_q;
    logic                    avg_valid_q;
    logic                    locked_q;
    logic                    lock_lost_q;

    // Lock FSM
    state_t            state_q, state_d;
    logic [LCNT_W-1:0] lockcnt_q, lockcnt_d;
    logic              lock_lost_d;

    // Datapath combinational signals
    logic signed [WIDTH-1:0] err;
    logic signed [ACC_W-1:0] err_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic [WIDTH-1:0]        abs_err;
    logic [WIDTH-1:0]        peak_next;
    logic                    window_close;
    logic signed [WIDTH-1:0] avg_new;
    logic signed [WIDTH:0]   avg_ext;
    logic [WIDTH:0]          abs_avg;
    logic                    good_win;
    logic                    bad_win;

    // Sample arithmetic: extended sum, saturating magnitude, new average
    always_comb begin
        err       = $signed(bus.error_i);
        err_ext   = {{LOG2_SAMPLES{err[WIDTH-1]}}, err};
        acc_sum   = acc_q + err_ext;
        if (!err[WIDTH-1]) begin
            abs_err = bus.error_i;
        end else if (bus.error_i == ERR_MIN) begin
            abs_err = ERR_MAX_MAG;
        end else begin
            abs_err = WIDTH'(-err);
        end
        peak_next    = (abs_err > run_peak_q) ? abs_err : run_peak_q;
        window_close = bus.sample_i && (count_q == {CNT_W{1'b1}});
        avg_new      = WIDTH'(acc_sum >>> LOG2_SAMPLES);
        avg_ext      = {avg_new[WIDTH-1], avg_new};
        abs_avg      = avg_new[WIDTH-1] ? $unsigned(-avg_ext) : $unsigned(avg_ext);
        good_win     = (abs_avg <= THRESH_GOOD);
        bad_win      = (abs_avg > THRESH_BAD);
    end

    // Accumulate samples and publish average/peak at window close
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q       <= '0;
            run_peak_q  <= '0;
            count_q     <= '0;
            avg_q       <= '0;
            peak_q      <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            if (bus.sample_i) begin
                if (window_close) begin
                    acc_q       <= '0;
                    run_peak_q  <= '0;
                    count_q     <= '0;
                    avg_q       <= avg_new;
                    peak_q      <= peak_next;
                    avg_valid_q <= 1'b1;
                end else begin
                    acc_q      <= acc_sum;
                    run_peak_q <= peak_next;
                    count_q    <= count_q + CNT_W'(1);
                end
            end
        end
    end

    // Lock FSM state register and registered lock outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= UNLOCKED;
            lockcnt_q   <= '0;
            locked_q    <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lockcnt_q   <= lockcnt_d;
            locked_q    <= (state_d == LOCKED);
            lock_lost_q <= lock_lost_d;
        end
    end

    // Lock FSM next state, evaluated only on the window-closing strobe
    always_comb begin
        state_d     = state_q;
        lockcnt_d   = lockcnt_q;
        lock_lost_d = 1'b0;
        if (window_close) begin
            unique case (state_q)
                UNLOCKED: begin
                    if (good_win) begin
                        lockcnt_d = LCNT_W'(1);
                        state_d   = (LCNT_TARGET == LCNT_W'(1)) ? LOCKED : ACQUIRING;
                    end
                end
                ACQUIRING: begin
                    if (good_win) begin
                        lockcnt_d = lockcnt_q + LCNT_W'(1);
                        if (lockcnt_d == LCNT_TARGET) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        lockcnt_d = '0;
                        state_d   = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (bad_win) begin
                        lockcnt_d   = '0;
                        state_d     = UNLOCKED;
                        lock_lost_d = 1'b1;
                    end
                end
                default: begin
                    lockcnt_d = '0;
                    state_d   = UNLOCKED;
                end
            endcase
        end
    end

    // Drive interface outputs from registers
    assign bus.avg_o       = avg_q;
    assign bus.peak_o      = peak_q;
    assign bus.avg_valid_o = avg_valid_q;
    assign bus.locked_o    = locked_q;
    assign bus.lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_error_lock_monitor.sv
// Directed self-checking bench for error_lock_monitor (default parameters).
module tb_error_lock_monitor;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   failed;
    int   valid_pulses;
    int   lost_pulses;
    int   v0;
    int   l0;

    error_lock_monitor_if #(.WIDTH(8)) bus ();

    error_lock_monitor #(
        .WIDTH(8), .LOG2_SAMPLES(4), .LOCK_THRESH(2), .LOCK_COUNT(8)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && bus.avg_valid_o) valid_pulses++;
        if (!rst && bus.lock_lost_o) lost_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One strobe held across one rising edge, then optional idle cycles
    task automatic strobe(input logic [7:0] v, input int gap);
        @(negedge clk);
        bus.sample_i = 1'b1;
        bus.error_i  = v;
        @(negedge clk);
        bus.sample_i = 1'b0;
        bus.error_i  = 8'h00;
        repeat (gap) @(negedge clk);
    endtask

    // Full window of a constant value; returns at the cycle avg_valid_o is high
    task automatic window(input logic [7:0] v);
        for (int i = 0; i < 16; i++) strobe(v, 0);
    endtask

    initial begin
        total = 0; passed = 0; failed = 0;
        valid_pulses = 0; lost_pulses = 0;
        bus.sample_i = 1'b0;
        bus.error_i  = 8'h00;
        rst = 1'b1;
        #13;
        check("reset_avg",    32'(bus.avg_o), 32'h0);
        check("reset_peak",   32'(bus.peak_o), 32'h0);
        check("reset_valid",  32'(bus.avg_valid_o), 32'h0);
        check("reset_locked", 32'(bus.locked_o), 32'h0);
        check("reset_lost",   32'(bus.lock_lost_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Idle with no strobes
        repeat (100) @(negedge clk);
        check("idle_avg",    32'(bus.avg_o), 32'h0);
        check("idle_peak",   32'(bus.peak_o), 32'h0);
        check("idle_valid_pulses", 32'(valid_pulses), 32'd0);
        check("idle_lost_pulses",  32'(lost_pulses), 32'd0);

        // +3 window with irregular gaps
        v0 = valid_pulses;
        for (int i = 0; i < 15; i++) strobe(8'h03, i % 6);
        check("plus3_no_early_valid", 32'(valid_pulses - v0), 32'd0);
        strobe(8'h03, 0);
        check("plus3_valid", 32'(bus.avg_valid_o), 32'h1);
        check("plus3_avg",   32'(bus.avg_o), 32'h03);
        check("plus3_peak",  32'(bus.peak_o), 32'h03);
        repeat (3) @(negedge clk);
        check("plus3_valid_drop", 32'(bus.avg_valid_o), 32'h0);
        check("plus3_one_pulse",  32'(valid_pulses - v0), 32'd1);
        check("plus3_unlocked",   32'(bus.locked_o), 32'h0);

        // Floor rounding: mean -0.5 -> -1
        for (int i = 0; i < 8; i++) strobe(8'hFF, 0);
        for (int i = 0; i < 8; i++) strobe(8'h00, 0);
        check("floor_valid", 32'(bus.avg_valid_o), 32'h1);
        check("floor_avg",   32'(bus.avg_o), 32'hFF);
        check("floor_peak",  32'(bus.peak_o), 32'h01);

        // Most negative input, saturated magnitude
        window(8'h80);
        check("min_avg",  32'(bus.avg_o), 32'h80);
        check("min_peak", 32'(bus.peak_o), 32'h7F);
        check("min_unlocked", 32'(bus.locked_o), 32'h0);

        // Acquire lock over 8 good windows
        for (int w = 1; w <= 8; w++) begin
            window(8'h01);
            check($sformatf("acq_w%0d_locked", w), 32'(bus.locked_o), (w == 8) ? 32'h1 : 32'h0);
        end
        check("acq_avg", 32'(bus.avg_o), 32'h01);

        // Hysteresis band keeps lock
        l0 = lost_pulses;
        window(8'h04);
        check("hyst_avg",    32'(bus.avg_o), 32'h04);
        check("hyst_locked", 32'(bus.locked_o), 32'h1);
        check("hyst_no_lost", 32'(bus.lock_lost_o), 32'h0);

        // Large error drops lock with a single lost pulse
        window(8'hFB);
        check("loss_avg",    32'(bus.avg_o), 32'hFB);
        check("loss_peak",   32'(bus.peak_o), 32'h05);
        check("loss_valid",  32'(bus.avg_valid_o), 32'h1);
        check("loss_lost",   32'(bus.lock_lost_o), 32'h1);
        check("loss_locked", 32'(bus.locked_o), 32'h0);
        @(negedge clk);
        check("loss_lost_drop", 32'(bus.lock_lost_o), 32'h0);
        repeat (3) @(negedge clk);
        check("loss_one_pulse", 32'(lost_pulses - l0), 32'd1);

        // 7 good then a bad window: count must clear
        for (int w = 0; w < 7; w++) window(8'h01);
        check("pre_break_locked", 32'(bus.locked_o), 32'h0);
        window(8'h03);
        check("break_avg",    32'(bus.avg_o), 32'h03);
        check("break_locked", 32'(bus.locked_o), 32'h0);
        window(8'h01);
        check("after_break_locked", 32'(bus.locked_o), 32'h0);

        // Async reset mid-window discards partial accumulation
        for (int i = 0; i < 7; i++) strobe(8'd50, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_avg",  32'(bus.avg_o), 32'h0);
        check("midrst_peak", 32'(bus.peak_o), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        v0 = valid_pulses;
        for (int i = 0; i < 15; i++) strobe(8'h02, 0);
        check("midrst_no_early_valid", 32'(valid_pulses - v0), 32'd0);
        strobe(8'h02, 0);
        check("midrst_valid", 32'(bus.avg_valid_o), 32'h1);
        check("midrst_avg2",  32'(bus.avg_o), 32'h02);
        check("midrst_peak2", 32'(bus.peak_o), 32'h02);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
